fetch_queue_unit: RTL and testbench
===================================

// Module: fetch_queue_unit
// PURPOSE
// - Parametrised fetch front end for the pipelined processor generation; replaces the single-cycle PC register/incrementer.
// - Holds the fetch PC and issues one outstanding request at a time to an instruction memory with variable latency.
// - Buffers returned instructions in a DEPTH-entry FIFO that feeds decode over a valid/ready handshake.
// - Handles execute-stage redirects (branch/jump) with a queue flush and drop of stale returns, plus HALT parking.
// PARAMETERS
// - WIDTH    16  instruction and address width in bits
// - DEPTH    4   instruction queue entries; power of 2, >= 2
// - RESET_PC 0   fetch PC loaded on reset
// - PC_STEP  2   byte increment per instruction
// PORTS
// - clk         in  1      clock; all state updates on the rising edge
// - rst         in  1      reset, asynchronous, active-low
// - imem_req    out 1      request strobe, one cycle per request
// - imem_addr   out WIDTH  request address; equals fetch_pc
// - imem_ack    in  1      read data valid for the oldest outstanding request
// - imem_rdata  in  WIDTH  instruction word, qualified by imem_ack
// - redirect    in  1      taken branch/jump from execute
// - redirect_pc in  WIDTH  new fetch address
// - halt        in  1      HALT decoded; stop fetching
// - dec_valid   out 1      queue head valid
// - dec_instr   out WIDTH  queue head instruction
// - dec_pc_inc  out WIDTH  queue head PC + PC_STEP
// - dec_ready   in  1      decode accepts the head this cycle
// - err         out 1      sticky misaligned-redirect flag
// - perf_stall  out 32     cycles with dec_ready=1 and dec_valid=0 (see CONFIGURATION)
// - perf_flush  out 32     number of redirects accepted (see CONFIGURATION)
// BEHAVIOUR
// - Reset (rst=0, async):
//   - state=S_IDLE, fetch_pc=RESET_PC, count=0, read/write pointers=0, queue storage=0.
//   - Outputs: imem_req=0, imem_addr=RESET_PC, dec_valid=0, dec_instr=0, dec_pc_inc=0, err=0, perf_*=0.
//   - Reset mid-request abandons it; the memory model must drop any pending ack on reset.
// - States and transitions:
//   - S_IDLE -> S_REQ on the first cycle after rst releases.
//   - S_REQ: imem_req = (count<DEPTH) & ~halt & ~redirect.
//     - Request issued -> S_WAIT.
//     - halt and no request -> S_HALT.
//   - S_WAIT: on imem_ack, push {imem_rdata, fetch_pc+PC_STEP}, then fetch_pc += PC_STEP.
//     - Next state is S_HALT if halt is high, else S_REQ.
//   - S_DISCARD: the next imem_ack is dropped -> S_REQ.
//   - S_HALT: no requests; the queue keeps draining. Leaves only on redirect (-> S_REQ) or reset.
// - Redirect (any state except S_IDLE):
//   - Same cycle: count:=0, pointers:=0, fetch_pc:=redirect_pc with bit0 cleared.
//   - In S_WAIT without a same-cycle ack -> S_DISCARD.
//   - In S_WAIT with a same-cycle ack: the ack is dropped -> S_REQ.
//   - redirect has priority over the ack, the pop and halt.
// - Misaligned redirect: redirect_pc[0]=1 sets err=1; err clears only on reset.
// - Queue:
//   - Push and pop in the same cycle leave count unchanged.
//   - Pop = dec_valid & dec_ready.
//   - Pointers wrap modulo DEPTH.
//   - A request is issued only when count<DEPTH, so an ack never finds the queue full.
// - Decode side:
//   - dec_valid = (count!=0).
//   - dec_instr and dec_pc_inc are read combinationally from the head entry.
// - Latency: an ack in cycle N gives dec_valid=1 in cycle N+1 when the queue was empty. There is no ack-to-decode bypass.
// - Arithmetic: fetch_pc wraps modulo 2^WIDTH; 0xFFFE+2 = 0x0000 at WIDTH=16.
// CONFIGURATION
// - FETCH_PERF_EN defined:
//   - perf_stall increments in cycles with dec_ready & ~dec_valid.
//   - perf_flush increments on each redirect.
//   - Both counters are 32-bit, wrap, and are cleared by reset.
// - FETCH_PERF_EN undefined: perf_stall and perf_flush are tied to 0 and no counter flops are built.
// TESTING (WIDTH=16, DEPTH=4, RESET_PC=0, PC_STEP=2)
// - Stream: ack latency 1, dec_ready=1 -> requests to 0x0000, 0x0002, 0x0004; decode sees them in order with dec_pc_inc 0x0002, 0x0004, 0x0006.
// - Backpressure: dec_ready=0 -> exactly 4 requests (0x0000-0x0006), then imem_req=0. dec_ready=1 for one pop -> next request to 0x0008.
// - Redirect in flight: redirect_pc=0x0040 during S_WAIT, ack 0xDEAD next cycle -> 0xDEAD never reaches decode; next imem_addr=0x0040; dec_valid=0 until it returns.
// - Halt: halt=1 with a request outstanding -> ack is queued, no further imem_req, queue drains. Redirect to 0x0010 -> next request to 0x0010.
// - Wrap and error:
//   - redirect_pc=0xFFFE -> dec_pc_inc 0x0000 and next request to 0x0000.
//   - redirect_pc=0x0013 -> err=1 sticky and next request to 0x0012.
// - FETCH_PERF_EN: 5 cycles of dec_ready=1 with the queue empty, plus 2 redirects -> perf_stall=5, perf_flush=2. Without the macro both read 0.

Source files
------------

// File: rtl/fetch_queue_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_unit_if
// Brief    : Instruction-memory request/ack bus and decode valid/ready bus
//            of the fetch front end.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_queue_unit_if #(
   parameter int WIDTH = 16
);
   logic             imem_req;
   logic [WIDTH-1:0] imem_addr;
   logic             imem_ack;
   logic [WIDTH-1:0] imem_rdata;
   logic             dec_valid;
   logic [WIDTH-1:0] dec_instr;
   logic [WIDTH-1:0] dec_pc_inc;
   logic             dec_ready;

   // master = fetch unit; slave = instruction memory plus decode stage
   modport master (
      output imem_req, imem_addr, dec_valid, dec_instr, dec_pc_inc,
      input  imem_ack, imem_rdata, dec_ready
   );
   modport slave (
      input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc_inc,
      output imem_ack, imem_rdata, dec_ready
   );
endinterface
`default_nettype wire

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_unit
// Brief    : Fetch front end: one outstanding imem request, DEPTH-entry
//            instruction queue to decode, redirect flush and HALT parking.
//            Optional macro FETCH_PERF_EN builds the stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue_unit #(
   parameter int               WIDTH    = 16,
   parameter int               DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter logic [WIDTH-1:0] PC_STEP  = WIDTH'(2)
) (
   input  logic                 clk,
   input  logic                 rst,
   fetch_queue_unit_if.master   bus,
   input  logic                 redirect,
   input  logic [WIDTH-1:0]     redirect_pc,
   input  logic                 halt,
   output logic                 err,
   output logic [31:0]          perf_stall,
   output logic [31:0]          perf_flush
);

   localparam int                 c_ptr_w = $clog2(DEPTH);
   localparam int                 c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REQ     = 3'd1,
      S_WAIT    = 3'd2,
      S_DISCARD = 3'd3,
      S_HALT    = 3'd4
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_fetch_pc;
   logic [c_cnt_w-1:0] r_count;
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [WIDTH-1:0]   r_instr_q [DEPTH];
   logic [WIDTH-1:0]   r_pcinc_q [DEPTH];
   logic               r_err;

   logic               w_redirect;
   logic               w_req;
   logic               w_push;
   logic               w_pop;
   logic [WIDTH-1:0]   w_pc_next;

   // redirect outranks ack, pop and halt; it is ignored only in S_IDLE
   assign w_redirect = redirect & (r_state != S_IDLE);
   assign w_req      = (r_state == S_REQ) & (r_count < c_depth) & ~halt & ~redirect;
   assign w_push     = (r_state == S_WAIT) & bus.imem_ack & ~w_redirect;
   assign w_pop      = bus.dec_valid & bus.dec_ready & ~w_redirect;
   assign w_pc_next  = r_fetch_pc + PC_STEP;

   assign bus.imem_req   = w_req;
   assign bus.imem_addr  = r_fetch_pc;
   assign bus.dec_valid  = (r_count != '0);
   assign bus.dec_instr  = r_instr_q[r_rd_ptr];
   assign bus.dec_pc_inc = r_pcinc_q[r_rd_ptr];
   assign err            = r_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_fetch_pc <= RESET_PC;
         r_count    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_err      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_instr_q[i] <= '0;
            r_pcinc_q[i] <= '0;
         end
      end else begin
         if (w_redirect) begin
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fetch_pc <= {redirect_pc[WIDTH-1:1], 1'b0};
            if (redirect_pc[0]) begin
               r_err <= 1'b1;
            end
         end else begin
            if (w_push) begin
               r_instr_q[r_wr_ptr] <= bus.imem_rdata;
               r_pcinc_q[r_wr_ptr] <= w_pc_next;
               r_wr_ptr            <= r_wr_ptr + c_ptr_w'(1);
               r_fetch_pc          <= w_pc_next;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + c_cnt_w'(1);
               2'b01:   r_count <= r_count - c_cnt_w'(1);
               default: r_count <= r_count;
            endcase
         end

         case (r_state)
            S_IDLE: r_state <= S_REQ;
            S_REQ: begin
               if (w_redirect)  r_state <= S_REQ;
               else if (w_req)  r_state <= S_WAIT;
               else if (halt)   r_state <= S_HALT;
            end
            S_WAIT: begin
               // a redirect without the ack leaves one stale return to drop
               if (w_redirect)        r_state <= bus.imem_ack ? S_REQ : S_DISCARD;
               else if (bus.imem_ack) r_state <= halt ? S_HALT : S_REQ;
            end
            S_DISCARD: begin
               if (bus.imem_ack) r_state <= S_REQ;
            end
            S_HALT: begin
               if (w_redirect) r_state <= S_REQ;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perf_stall <= '0;
         r_perf_flush <= '0;
      end else begin
         if (bus.dec_ready & ~bus.dec_valid) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
         if (w_redirect) begin
            r_perf_flush <= r_perf_flush + 32'd1;
         end
      end
   end

   assign perf_stall = r_perf_stall;
   assign perf_flush = r_perf_flush;
`else
   assign perf_stall = '0;
   assign perf_flush = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue_unit
// Brief    : Self-checking bench for fetch_queue_unit with a variable-latency
//            memory model and a decode-side scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_unit;

`ifdef FETCH_PERF_EN
   localparam int c_exp_stall = 5;
   localparam int c_exp_flush = 2;
`else
   localparam int c_exp_stall = 0;
   localparam int c_exp_flush = 0;
`endif

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc_inc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic        halt = 1'b0;
   logic        err;
   logic [31:0] perf_stall;
   logic [31:0] perf_flush;

   int errors = 0;
   int checks = 0;
   int pop_cnt = 0;

   exp_t        sb[$];
   logic [15:0] req_log[$];

   // memory model state
   int          mem_lat = 1;
   bit          pend = 1'b0;
   int          wait_cnt = 0;
   logic [15:0] p_addr = 16'h0000;
   bit          m_req_s = 1'b0;
   logic [15:0] m_addr_s = 16'h0000;
   bit          discard_next = 1'b0;
   bit          ovr_en = 1'b0;
   logic [15:0] ovr_data = 16'h0000;

   always #5 clk = ~clk;

   fetch_queue_unit_if #(.WIDTH(16)) bus ();

   fetch_queue_unit #(
      .WIDTH(16), .DEPTH(4), .RESET_PC(16'h0000), .PC_STEP(16'd2)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .redirect(redirect),
      .redirect_pc(redirect_pc), .halt(halt), .err(err),
      .perf_stall(perf_stall), .perf_flush(perf_flush)
   );

   function automatic logic [15:0] instr_of(input logic [15:0] a);
      return a ^ 16'h5A00;
   endfunction

   // mid-cycle: capture requests and score every decode pop
   always @(negedge clk) begin
      exp_t e;
      m_req_s  = (rst === 1'b1) && (bus.imem_req === 1'b1);
      m_addr_s = bus.imem_addr;
      if (m_req_s) req_log.push_back(bus.imem_addr);
      if (rst === 1'b1 && bus.dec_valid === 1'b1 && bus.dec_ready === 1'b1 && redirect !== 1'b1) begin
         pop_cnt++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got instr=%h pc_inc=%h, expected no valid entry", bus.dec_instr, bus.dec_pc_inc);
         end else begin
            e = sb.pop_front();
            if (bus.dec_instr !== e.instr || bus.dec_pc_inc !== e.pc_inc) begin
               errors++;
               $display("FAIL pop_data: got instr=%h pc_inc=%h, expected instr=%h pc_inc=%h",
                        bus.dec_instr, bus.dec_pc_inc, e.instr, e.pc_inc);
            end
         end
      end
   end

   // memory: ack arrives mem_lat cycles after the request cycle
   always @(posedge clk) begin
      exp_t ne;
      #1;
      bus.imem_ack = 1'b0;
      if (rst !== 1'b1) begin
         pend           = 1'b0;
         bus.imem_rdata = 16'h0000;
      end else begin
         if (m_req_s) begin
            pend     = 1'b1;
            p_addr   = m_addr_s;
            wait_cnt = mem_lat;
         end
         if (pend) begin
            wait_cnt--;
            if (wait_cnt <= 0) begin
               pend           = 1'b0;
               bus.imem_ack   = 1'b1;
               bus.imem_rdata = ovr_en ? ovr_data : instr_of(p_addr);
               ovr_en         = 1'b0;
               if (discard_next) begin
                  discard_next = 1'b0;
               end else begin
                  ne.instr  = bus.imem_rdata;
                  ne.pc_inc = p_addr + 16'd2;
                  sb.push_back(ne);
               end
            end
         end
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = 16'h0000;
      bus.dec_ready = 1'b0; mem_lat = 1;
      cyc(2);
      sb.delete(); req_log.delete(); discard_next = 1'b0; ovr_en = 1'b0;
      rst = 1'b1;
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.imem_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // redirect while the request found by wait_req is in S_WAIT (mem_lat=2)
   task automatic redirect_in_wait(input logic [15:0] pc);
      bit ok;
      wait_req(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL redir_req_timeout: got no imem_req, expected one"); end
      cyc();
      redirect = 1'b1; redirect_pc = pc; discard_next = 1'b1; sb.delete();
      cyc();
      redirect = 1'b0; req_log.delete();
   endtask

   task automatic test_reset();
      rst = 1'b0; bus.dec_ready = 1'b0;
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b0)       begin errors++; $display("FAIL rst_req: got %b expected 0", bus.imem_req); end
      checks++; if (bus.imem_addr !== 16'h0000)  begin errors++; $display("FAIL rst_addr: got %h expected 0000", bus.imem_addr); end
      checks++; if (bus.dec_valid !== 1'b0)      begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.dec_valid); end
      checks++; if (bus.dec_instr !== 16'h0000)  begin errors++; $display("FAIL rst_instr: got %h expected 0000", bus.dec_instr); end
      checks++; if (bus.dec_pc_inc !== 16'h0000) begin errors++; $display("FAIL rst_pcinc: got %h expected 0000", bus.dec_pc_inc); end
      checks++; if (err !== 1'b0)                begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
      checks++; if (perf_stall !== 32'd0 || perf_flush !== 32'd0) begin
         errors++; $display("FAIL rst_perf: got stall=%0d flush=%0d expected 0 0", perf_stall, perf_flush); end
   endtask

   task automatic test_stream();
      bit ok = 1'b0;
      int p0;
      do_reset();
      bus.dec_ready = 1'b1; p0 = pop_cnt;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.imem_ack === 1'b1) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL stream_ack_timeout: got no ack, expected one"); end
      else begin
         checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL no_bypass: got dec_valid=%b expected 0", bus.dec_valid); end
         @(negedge clk);
         checks++; if (bus.dec_valid !== 1'b1) begin errors++; $display("FAIL ack_to_valid: got dec_valid=%b expected 1", bus.dec_valid); end
      end
      cyc(6);
      @(negedge clk);
      checks++;
      if (req_log.size() < 3 || req_log[0] !== 16'h0000 || req_log[1] !== 16'h0002 || req_log[2] !== 16'h0004) begin
         errors++; $display("FAIL stream_addr: got %0d requests (first %h), expected 0000 0002 0004", req_log.size(), req_log[0]);
      end
      checks++; if (pop_cnt - p0 < 3) begin errors++; $display("FAIL stream_pops: got %0d expected >=3", pop_cnt - p0); end
   endtask

   task automatic test_backpressure();
      do_reset();
      cyc(20);
      @(negedge clk);
      checks++;
      if (req_log.size() != 4 || req_log[0] !== 16'h0000 || req_log[1] !== 16'h0002 ||
          req_log[2] !== 16'h0004 || req_log[3] !== 16'h0006) begin
         errors++; $display("FAIL bp_requests: got %0d requests, expected exactly 0000..0006", req_log.size());
      end
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_full: got %b expected 0", bus.imem_req); end
      checks++; if (bus.dec_valid !== 1'b1 || bus.dec_instr !== instr_of(16'h0000)) begin
         errors++; $display("FAIL bp_head: got valid=%b instr=%h expected 1 %h", bus.dec_valid, bus.dec_instr, instr_of(16'h0000)); end
      cyc();
      bus.dec_ready = 1'b1;
      cyc();
      bus.dec_ready = 1'b0;
      cyc(4);
      @(negedge clk);
      checks++;
      if (req_log.size() != 5 || req_log[4] !== 16'h0008) begin
         errors++; $display("FAIL bp_next_req: got %0d requests (last %h), expected 5 ending 0008", req_log.size(), req_log[$]);
      end
   endtask

   task automatic test_redirect();
      do_reset();
      bus.dec_ready = 1'b1; mem_lat = 2;
      ovr_en = 1'b1; ovr_data = 16'hDEAD;
      redirect_in_wait(16'h0040);
      @(negedge clk);
      checks++; if (bus.imem_ack !== 1'b1 || bus.imem_req !== 1'b0) begin
         errors++; $display("FAIL redir_discard: got ack=%b req=%b expected 1 0", bus.imem_ack, bus.imem_req); end
      cyc();
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0040) begin
         errors++; $display("FAIL redir_addr: got req=%b addr=%h expected 1 0040", bus.imem_req, bus.imem_addr); end
      for (int i = 0; i < 2; i++) begin
         cyc();
         @(negedge clk);
         checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_early: got %b expected 0", bus.dec_valid); end
      end
      cyc();
      @(negedge clk);
      checks++; if (bus.dec_valid !== 1'b1 || bus.dec_instr !== instr_of(16'h0040)) begin
         errors++; $display("FAIL redir_return: got valid=%b instr=%h expected 1 %h", bus.dec_valid, bus.dec_instr, instr_of(16'h0040)); end
   endtask

   task automatic test_halt();
      bit ok;
      int p0;
      do_reset();
      bus.dec_ready = 1'b1; mem_lat = 2; p0 = pop_cnt;
      wait_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL halt_req_timeout: got no imem_req, expected one"); end
      cyc();
      halt = 1'b1;
      cyc(10);
      @(negedge clk);
      checks++; if (req_log.size() != 1) begin errors++; $display("FAIL halt_no_req: got %0d requests expected 1", req_log.size()); end
      checks++; if (bus.dec_valid !== 1'b0 || pop_cnt - p0 != 1) begin
         errors++; $display("FAIL halt_drain: got valid=%b pops=%0d expected 0 1", bus.dec_valid, pop_cnt - p0); end
      cyc();
      redirect = 1'b1; redirect_pc = 16'h0010; halt = 1'b0;
      cyc();
      redirect = 1'b0;
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0010) begin
         errors++; $display("FAIL halt_resume: got req=%b addr=%h expected 1 0010", bus.imem_req, bus.imem_addr); end
   endtask

   task automatic test_wrap_err();
      int p0;
      do_reset();
      bus.dec_ready = 1'b1; mem_lat = 2;
      redirect_in_wait(16'hFFFE);
      p0 = pop_cnt;
      cyc();
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'hFFFE) begin
         errors++; $display("FAIL wrap_req: got req=%b addr=%h expected 1 FFFE", bus.imem_req, bus.imem_addr); end
      cyc(4);
      @(negedge clk);
      checks++; if (req_log.size() != 2 || req_log[1] !== 16'h0000 || pop_cnt - p0 != 1) begin
         errors++; $display("FAIL wrap_next: got %0d requests (last %h) pops=%0d expected FFFE 0000 pops=1", req_log.size(), req_log[$], pop_cnt - p0); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_aligned: got %b expected 0", err); end
      redirect_in_wait(16'h0013);
      cyc();
      @(negedge clk);
      checks++; if (err !== 1'b1 || bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0012) begin
         errors++; $display("FAIL err_set: got err=%b req=%b addr=%h expected 1 1 0012", err, bus.imem_req, bus.imem_addr); end
      redirect_in_wait(16'h0020);
      cyc();
      @(negedge clk);
      checks++; if (err !== 1'b1 || bus.imem_addr !== 16'h0020) begin
         errors++; $display("FAIL err_sticky: got err=%b addr=%h expected 1 0020", err, bus.imem_addr); end
   endtask

   task automatic test_perf();
      do_reset();
      halt = 1'b1;
      @(negedge clk);
      checks++; if (perf_stall !== 32'd0 || perf_flush !== 32'd0) begin
         errors++; $display("FAIL perf_cleared: got stall=%0d flush=%0d expected 0 0", perf_stall, perf_flush); end
      cyc(2);
      bus.dec_ready = 1'b1;
      cyc(5);
      bus.dec_ready = 1'b0;
      redirect = 1'b1; redirect_pc = 16'h0030;
      cyc();
      redirect = 1'b0;
      cyc();
      redirect = 1'b1;
      cyc();
      redirect = 1'b0;
      cyc(2);
      @(negedge clk);
      checks++; if (perf_stall !== 32'(c_exp_stall) || perf_flush !== 32'(c_exp_flush)) begin
         errors++; $display("FAIL perf_counts: got stall=%0d flush=%0d expected %0d %0d",
                            perf_stall, perf_flush, c_exp_stall, c_exp_flush); end
      checks++; if (req_log.size() != 0) begin errors++; $display("FAIL perf_halted: got %0d requests expected 0", req_log.size()); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected run to complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.dec_ready = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_halt();
      test_wrap_err();
      test_perf();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
